alu_operand_loader: RTL and testbench
=====================================

Name: alu_operand_loader

Overview:
- Bus-side driver for the ALU virtual board's nibble-wide operand load interface.
- Accepts a complete ALU request (two 8-bit operands, command, carry-in) over a valid/ready handshake.
- Serialises the operands into four nibble-write beats on arg/select_args/lo_hi_arg/load_args, waits for the ALU to settle, then returns result, flags and carry over a valid/ready response handshake.
- Replaces manual switch entry; sits between a host/test sequencer and the board top.

Parameters:
- NIBBLE_W, 4, width of one load beat (arg bus).
- DATA_W, 8, operand and result width; must equal 2*NIBBLE_W.
- SELECT_W, 3, ALU command width.
- SETTLE_CYCLES, 1, wait cycles after the last beat before the result is sampled; must be at least 1 (elaboration assertion).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  loader can accept a request.
- req_a  in  DATA_W  operand A.
- req_b  in  DATA_W  operand B.
- req_command  in  SELECT_W  ALU command.
- req_carry_in  in  1  ALU carry-in.
- arg  out  NIBBLE_W  nibble to board.
- select_args  out  1  write address bit 0.
- lo_hi_arg  out  1  write address bit 1.
- load_args  out  1  write strobe, one cycle per beat.
- command  out  SELECT_W  ALU command to board.
- carry_in  out  1  ALU carry-in to board.
- result  in  DATA_W  board ALU result.
- flags  in  8  board flag vector.
- carry_out  in  1  board carry-out.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  DATA_W  captured result.
- rsp_flags  out  8  captured flags.
- rsp_carry  out  1  captured carry_out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All registered outputs clear to 0: arg, select_args, lo_hi_arg, load_args, command, carry_in, rsp_valid, rsp_result, rsp_flags, rsp_carry.
- req_ready is combinational, high exactly in IDLE, so it is 1 immediately after reset release.
- Write address {lo_hi_arg, select_args}:
  - 00 = A[3:0]
  - 01 = A[7:4]
  - 10 = B[3:0]
  - 11 = B[7:4]
- States: IDLE, LOAD, SETTLE, RESP.
- IDLE:
  - On req_valid && req_ready at edge t0, latch req_a, req_b, req_command, req_carry_in; go to LOAD with beat counter 0.
  - command/carry_in take the latched values from cycle t0+1 and hold until the next accept.
- LOAD:
  - Beat k (k=0..3) occupies cycle t0+1+k.
  - Drives load_args=1, address k, and arg = the nibble for address k.
  - After beat 3 go to SETTLE; load_args returns to 0 at t0+5.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, t0+5 .. t0+4+SETTLE_CYCLES.
  - At the edge ending the last settle cycle, capture result/flags/carry_out into rsp_*; go to RESP.
- RESP:
  - rsp_valid=1 from cycle t0+5+SETTLE_CYCLES.
  - rsp_* stay stable until rsp_valid && rsp_ready; then rsp_valid clears and state returns to IDLE next cycle.
  - rsp_* hold their values after the handshake.
- No overlap: a new request is never accepted while busy. With SETTLE_CYCLES=1, the back-to-back period is 7 cycles.
- arg and address outputs hold the last beat's values outside LOAD; only load_args is a strobe.
- Beat counter is 2 bits and wraps naturally 3→0; no other wrap cases.
- Reset mid-transaction: outputs clear the same instant (load_args drops combinationally with the async reset), the transaction is discarded and no response is produced. Board operand registers may hold partially written values; the next full transaction rewrites all four nibbles.
- rsp_ready high in the first RESP cycle: one-cycle response, IDLE on the next cycle.
- req_valid dropping before acceptance: nothing latched. Request inputs are ignored after acceptance.

Decomposition:
- Shared package holds:
  - state enum type;
  - 2-bit write-address constants (ADDR_A_LO, ADDR_A_HI, ADDR_B_LO, ADDR_B_HI);
  - NIBBLE_W, DATA_W, SELECT_W defaults;
  - ALU command encodings (CLR=0, B_MINUS_A=1, A_MINUS_B=2, A_PLUS_B=3, XOR=4, OR=5, AND=6, PRESET=7).
- Single flat module; no sub-module warranted.
- The bench instantiates the board top as the DUT's load target.

Test Plan:
1. Reset, then A=0x3C, B=0x15, command=3 (add), carry_in=0 → beats arg=C,3,5,1 at addresses 00,01,10,11 in cycles t0+1..t0+4; rsp_result=0x51, rsp_carry=0, rsp_valid at t0+6.
2. A=0xFF, B=0x01, add, carry_in=0 → rsp_result=0x00, rsp_carry=1, rsp_flags[0]=1.
3. rsp_ready held low 10 cycles after rsp_valid → rsp_valid stays 1, rsp_* unchanged, req_ready=0, no load_args pulses; release → IDLE next cycle.
4. req_valid held high and rsp_ready=1 for three requests → accepts exactly 7 cycles apart; each response matches the board model.
5. reset pulsed low during beat 2 → load_args=0 and all outputs 0 immediately; after release req_ready=1; next request A=0x0A, B=0x05, command=2 (A minus B) → rsp_result=0x05.
6. SETTLE_CYCLES=3, same stimulus as scenario 1 → identical beats; rsp_valid first at t0+8; rsp_result=0x51.

Source files
------------

// File: rtl/alu_operand_loader_pkg.sv
// rtl/alu_operand_loader_pkg.sv - shared types and constants for the ALU operand loader
package alu_operand_loader_pkg;

  localparam int DEF_NIBBLE_W = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_SELECT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RESP
  } state_t;

  // Board write address is {lo_hi_arg, select_args}
  localparam logic [1:0] ADDR_A_LO = 2'b00;
  localparam logic [1:0] ADDR_A_HI = 2'b01;
  localparam logic [1:0] ADDR_B_LO = 2'b10;
  localparam logic [1:0] ADDR_B_HI = 2'b11;

  typedef enum logic [2:0] {
    CMD_CLR       = 3'd0,
    CMD_B_MINUS_A = 3'd1,
    CMD_A_MINUS_B = 3'd2,
    CMD_A_PLUS_B  = 3'd3,
    CMD_XOR       = 3'd4,
    CMD_OR        = 3'd5,
    CMD_AND       = 3'd6,
    CMD_PRESET    = 3'd7
  } alu_cmd_t;

endpackage

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - serialises ALU operands into nibble beats and returns the settled result
module alu_operand_loader
  import alu_operand_loader_pkg::*;
#(
  parameter int NIBBLE_W      = DEF_NIBBLE_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int SELECT_W      = DEF_SELECT_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  input  logic [SELECT_W-1:0] req_command,
  input  logic                req_carry_in,
  output logic [NIBBLE_W-1:0] arg,
  output logic                select_args,
  output logic                lo_hi_arg,
  output logic                load_args,
  output logic [SELECT_W-1:0] command,
  output logic                carry_in,
  input  logic [DATA_W-1:0]   result,
  input  logic [7:0]          flags,
  input  logic                carry_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_result,
  output logic [7:0]          rsp_flags,
  output logic                rsp_carry,
  output logic                busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (DATA_W != 2 * NIBBLE_W) begin : g_bad_width
    $error("DATA_W must equal 2*NIBBLE_W");
  end

  state_t              state, state_n;
  logic [1:0]          beat;
  logic [CNT_W-1:0]    settle_cnt;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [1:0]          wr_addr;
  logic [DATA_W-1:0]   src;
  logic [NIBBLE_W-1:0] wr_nibble;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // The first beat is launched on the accept edge, so it reads the request bus directly
  always_comb begin
    wr_addr   = (state == ST_IDLE) ? ADDR_A_LO : beat + 2'd1;
    if (wr_addr[1]) src = (state == ST_IDLE) ? req_b : b_q;
    else            src = (state == ST_IDLE) ? req_a : a_q;
    wr_nibble = wr_addr[0] ? src[DATA_W-1 -: NIBBLE_W] : src[NIBBLE_W-1:0];
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (req_valid)                state_n = ST_LOAD;
      ST_LOAD:   if (beat == 2'd3)             state_n = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_n = ST_RESP;
      ST_RESP:   if (rsp_ready)                state_n = ST_IDLE;
      default:                                 state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      beat        <= '0;
      settle_cnt  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      arg         <= '0;
      select_args <= 1'b0;
      lo_hi_arg   <= 1'b0;
      load_args   <= 1'b0;
      command     <= '0;
      carry_in    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_carry   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            a_q                      <= req_a;
            b_q                      <= req_b;
            command                  <= req_command;
            carry_in                 <= req_carry_in;
            beat                     <= 2'd0;
            load_args                <= 1'b1;
            {lo_hi_arg, select_args} <= wr_addr;
            arg                      <= wr_nibble;
          end
        end
        ST_LOAD: begin
          beat <= beat + 2'd1;
          if (beat != 2'd3) begin
            load_args                <= 1'b1;
            {lo_hi_arg, select_args} <= wr_addr;
            arg                      <= wr_nibble;
          end else begin
            load_args  <= 1'b0;
            settle_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            rsp_result <= result;
            rsp_flags  <= flags;
            rsp_carry  <= carry_out;
            rsp_valid  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - randomized bench: two loaders (settle 1 and 3) driving behavioural boards
module tb_alu_operand_loader;

  localparam int NS = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [2:0] req_command = '0;
  logic       req_carry_in = 1'b0;
  logic       rsp_ready = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  int         lat [NS];
  logic [7:0] res_s [NS];
  logic [7:0] flg_s [NS];
  logic       cry_s [NS];

  always #5 clock = ~clock;

  task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got %0h want %0h at %0t", nm, g, act, exp, $time);
  endtask

  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] c, input logic ci);
    case (c)
      3'd0:    return 9'd0;
      3'd1:    return {1'b0, b} + {1'b0, ~a} + 9'd1;
      3'd2:    return {1'b0, a} + {1'b0, ~b} + 9'd1;
      3'd3:    return {1'b0, a} + {1'b0, b} + {8'd0, ci};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, a | b};
      3'd6:    return {1'b0, a & b};
      default: return 9'h0FF;
    endcase
  endfunction

  function automatic logic [7:0] flags_fn(input logic [7:0] a, input logic [7:0] b, input logic [8:0] r);
    return {a[3:0] ^ b[3:0], r[8], r[7], ^r[7:0], r[7:0] == 8'd0};
  endfunction

  function automatic logic [3:0] nib_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] k);
    case (k)
      2'd0:    return a[3:0];
      2'd1:    return a[7:4];
      2'd2:    return b[3:0];
      default: return b[7:4];
    endcase
  endfunction

  for (genvar g = 0; g < NS; g++) begin : u
    localparam int S = (g == 0) ? 1 : 3;

    logic       req_ready, select_args, lo_hi_arg, load_args, carry_in;
    logic       rsp_valid, rsp_carry, busy;
    logic [3:0] arg;
    logic [2:0] command;
    logic [7:0] rsp_result, rsp_flags;
    logic [7:0] br_a = '0;
    logic [7:0] br_b = '0;
    logic [8:0] b_alu;
    logic [7:0] b_flags;

    assign b_alu   = alu_fn(br_a, br_b, command, carry_in);
    assign b_flags = flags_fn(br_a, br_b, b_alu);

    alu_operand_loader #(.SETTLE_CYCLES(S)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_command(req_command), .req_carry_in(req_carry_in),
      .arg(arg), .select_args(select_args), .lo_hi_arg(lo_hi_arg), .load_args(load_args),
      .command(command), .carry_in(carry_in),
      .result(b_alu[7:0]), .flags(b_flags), .carry_out(b_alu[8]),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_carry(rsp_carry),
      .busy(busy)
    );

    // Board operand registers: one nibble written per load strobe
    always @(posedge clock) begin
      if (load_args) begin
        case ({lo_hi_arg, select_args})
          2'b00: br_a[3:0] <= arg;
          2'b01: br_a[7:4] <= arg;
          2'b10: br_b[3:0] <= arg;
          default: br_b[7:4] <= arg;
        endcase
      end
    end

    // n = cycles since acceptance (0 when idle); response expected at n = 5+S
    int         n = 0;
    logic [7:0] ma, mb, m_res, m_flags;
    logic [2:0] mc;
    logic       mcin, m_cout;
    logic [1:0] m_addr;
    logic [3:0] m_arg;

    always @(posedge clock or negedge reset) begin
      if (!reset) begin
        n <= 0; ma <= '0; mb <= '0; mc <= '0; mcin <= 1'b0;
        m_res <= '0; m_flags <= '0; m_cout <= 1'b0; m_addr <= '0; m_arg <= '0;
      end else if (n == 0) begin
        if (req_valid) begin
          n <= 1; ma <= req_a; mb <= req_b; mc <= req_command; mcin <= req_carry_in;
          m_addr <= 2'd0; m_arg <= req_a[3:0];
        end
      end else if (n <= 3) begin
        n <= n + 1; m_addr <= 2'(n); m_arg <= nib_fn(ma, mb, 2'(n));
      end else if (n < 4 + S) begin
        n <= n + 1;
      end else if (n == 4 + S) begin
        n <= n + 1;
        {m_cout, m_res} <= alu_fn(ma, mb, mc, mcin);
        m_flags <= flags_fn(ma, mb, alu_fn(ma, mb, mc, mcin));
      end else if (rsp_ready) begin
        n <= 0;
      end
    end

    always @(negedge clock) begin
      check("req_ready", g, req_ready, n == 0);
      check("busy", g, busy, n != 0);
      check("load_args", g, load_args, (n >= 1) && (n <= 4));
      check("addr", g, {lo_hi_arg, select_args}, m_addr);
      check("arg", g, arg, m_arg);
      check("command", g, command, mc);
      check("carry_in", g, carry_in, mcin);
      check("rsp_valid", g, rsp_valid, n == 5 + S);
      check("rsp_result", g, rsp_result, m_res);
      check("rsp_flags", g, rsp_flags, m_flags);
      check("rsp_carry", g, rsp_carry, m_cout);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (!(u[0].n == 0 && u[1].n == 0) && k < bound) begin
      tick();
      k++;
    end
    check("idle_reached", 0, k < bound, 1'b1);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c, input logic ci);
    req_a = a; req_b = b; req_command = c; req_carry_in = ci; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Records the cycle offset (from acceptance) and content of each instance's first response
  task automatic collect(input int t_start);
    int t = t_start;
    for (int i = 0; i < NS; i++) lat[i] = -1;
    while ((lat[0] < 0 || lat[1] < 0) && t < 40) begin
      if (lat[0] < 0 && u[0].rsp_valid) begin
        lat[0] = t; res_s[0] = u[0].rsp_result; flg_s[0] = u[0].rsp_flags; cry_s[0] = u[0].rsp_carry;
      end
      if (lat[1] < 0 && u[1].rsp_valid) begin
        lat[1] = t; res_s[1] = u[1].rsp_result; flg_s[1] = u[1].rsp_flags; cry_s[1] = u[1].rsp_carry;
      end
      tick();
      t++;
    end
  endtask

  initial begin
    logic [3:0] s1_nib [4];
    logic [7:0] ra, rb;
    logic [2:0] rc;
    logic       rci;
    int         pulses, nacc, k;
    int         acc [3];

    s1_nib = '{4'hC, 4'h3, 4'h5, 4'h1};

    tick(); tick();
    check("reset_load_args", 0, u[0].load_args, 1'b0);
    reset = 1'b1;
    #1;
    check("ready_after_reset", 0, u[0].req_ready, 1'b1);

    // Scenario 1 (and 6 on instance 1): beat order and response latency
    rsp_ready = 1'b1;
    issue(8'h3C, 8'h15, 3'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < NS; g++) begin
        check("s1_load", g, (g == 0) ? u[0].load_args : u[1].load_args, 1'b1);
        check("s1_addr", g, (g == 0) ? {u[0].lo_hi_arg, u[0].select_args}
                                     : {u[1].lo_hi_arg, u[1].select_args}, i);
        check("s1_arg", g, (g == 0) ? u[0].arg : u[1].arg, s1_nib[i]);
      end
      tick();
    end
    collect(5);
    check("s1_latency", 0, lat[0], 6);
    check("s1_latency", 1, lat[1], 8);
    check("s1_result", 0, res_s[0], 8'h51);
    check("s1_result", 1, res_s[1], 8'h51);
    check("s1_carry", 0, cry_s[0], 1'b0);

    // Scenario 2: add overflow
    wait_idle(50);
    issue(8'hFF, 8'h01, 3'd3, 1'b0);
    collect(1);
    check("s2_result", 0, res_s[0], 8'h00);
    check("s2_carry", 0, cry_s[0], 1'b1);
    check("s2_zero_flag", 0, flg_s[0][0], 1'b1);
    check("s2_result", 1, res_s[1], 8'h00);

    // Scenario 3: response back-pressure
    wait_idle(50);
    rsp_ready = 1'b0;
    ra = 8'($urandom); rb = 8'($urandom); rc = 3'($urandom); rci = 1'($urandom);
    issue(ra, rb, rc, rci);
    k = 0;
    while (!u[0].rsp_valid && k < 20) begin tick(); k++; end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (u[0].load_args) pulses++;
    end
    check("s3_valid_held", 0, u[0].rsp_valid, 1'b1);
    check("s3_result_held", 0, u[0].rsp_result, alu_fn(ra, rb, rc, rci) & 9'h0FF);
    check("s3_ready_low", 0, u[0].req_ready, 1'b0);
    check("s3_no_pulses", 0, pulses, 0);
    rsp_ready = 1'b1;
    tick();
    check("s3_idle_after", 0, u[0].req_ready, 1'b1);

    // Scenario 4: back-to-back requests
    wait_idle(50);
    req_valid = 1'b1;
    nacc = 0; k = 0;
    while (nacc < 3 && k < 40) begin
      if (u[0].req_ready) begin acc[nacc] = k; nacc++; end
      req_a = 8'($urandom); req_b = 8'($urandom); req_command = 3'($urandom); req_carry_in = 1'($urandom);
      tick();
      k++;
    end
    req_valid = 1'b0;
    check("s4_accepts", 0, nacc, 3);
    check("s4_gap1", 0, acc[1] - acc[0], 7);
    check("s4_gap2", 0, acc[2] - acc[1], 7);

    // Scenario 5: reset during beat 2
    wait_idle(50);
    issue(8'hA7, 8'h5E, 3'd4, 1'b1);
    tick(); tick();
    check("s5_beat2_load", 0, u[0].load_args, 1'b1);
    reset = 1'b0;
    #1;
    check("s5_rst_load", 0, u[0].load_args, 1'b0);
    check("s5_rst_arg", 0, u[0].arg, 4'h0);
    check("s5_rst_cmd", 0, u[0].command, 3'd0);
    check("s5_rst_load", 1, u[1].load_args, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    check("s5_ready", 0, u[0].req_ready, 1'b1);
    issue(8'h0A, 8'h05, 3'd2, 1'b0);
    collect(1);
    check("s5_result", 0, res_s[0], 8'h05);
    check("s5_result", 1, res_s[1], 8'h05);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      req_valid    = 1'($urandom);
      req_a        = 8'($urandom);
      req_b        = 8'($urandom);
      req_command  = 3'($urandom);
      req_carry_in = 1'($urandom);
      rsp_ready    = ($urandom_range(0, 9) < 6);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(50);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
